keccak_absorb_pad: RTL and testbench
====================================

// Module: keccak_absorb_pad
// PURPOSE
//  Upstream absorb stage of the Keccak engine. Packs DWIDTH-bit input beats into
//  rate-sized blocks for the selected mode and applies domain suffix plus pad10*1.
//  Hands each block to the permutation core, which XORs it into the state.
//  Output blocks are byte-aligned. Beats that straddle a block boundary are split
//  internally.
// PARAMETERS
//  DWIDTH      256  input beat width; taken from keccak_pkg, not overridable
//  MAX_RATE_B  168  largest rate in bytes (SHAKE128); sizes the block buffer
// PORTS
//  clk         in   1                 clock
//  rst_n       in   1                 asynchronous active-low reset
//  start_i     in   1                 begin message; latches mode_i, clears buffer
//  mode_i      in   MODE_SEL_WIDTH    keccak_mode: SHA3_256/SHA3_512/SHAKE128/SHAKE256
//  s_data_i    in   DWIDTH            input bytes; byte k = bits [8k+7:8k]
//  s_keep_i    in   KEEP_WIDTH        valid-byte mask; contiguous from bit 0
//  s_last_i    in   1                 final beat of message
//  s_valid_i   in   1                 input beat valid
//  s_ready_o   out  1                 input beat accepted when valid&ready
//  m_block_o   out  MAX_RATE_B*8      rate block; bytes >= rate are zero
//  m_last_o    out  1                 block is padded final block
//  m_valid_o   out  1                 block valid
//  m_ready_i   in   1                 permutation core takes block
//  busy_o      out  1                 FSM not in IDLE
// BEHAVIOUR
//  Reset: s_ready_o=0, m_valid_o=0, m_last_o=0, m_block_o=0, busy_o=0, FSM=IDLE.
//  FSM: IDLE -start_i-> FILL. FILL -fill==rate-> EMIT.
//   FILL -s_last accepted, fill<rate-> EMIT_LAST (pad applied same cycle).
//   EMIT -handshake-> FILL, or PAD_ONLY if the last beat ended exactly on a boundary.
//   PAD_ONLY -1 cycle-> EMIT_LAST. EMIT_LAST -handshake-> IDLE.
//  Byte count n = popcount(s_keep_i); n=0 allowed only with s_last_i (empty tail).
//  s_ready_o = (state==FILL) && !carry_pending. Accepted bytes are written at
//   offset fill; fill += n.
//  Straddle: if fill+n > rate, the overflow bytes (n-(rate-fill)) go to a carry
//   register. After the EMIT handshake the carry is written at offset 0. If that
//   beat had s_last, pad is applied in the same cycle (-> EMIT_LAST).
//  Pad: byte[fill] ^= suffix (0x06 SHA3, 0x1F SHAKE); byte[rate-1] ^= 0x80.
//   When fill==rate-1 both hit one byte (0x86 / 0x9F).
//  Latency: m_valid_o rises the cycle after the filling or last beat is accepted.
//   m_block_o/m_last_o are held stable while m_valid_o && !m_ready_i.
//   The buffer is cleared on the handshake cycle.
//  start_i in non-IDLE: ignored. mode_i is sampled only on start_i.
//  Async reset mid-message drops all partial data; no output pulse.
//  rate: 136 B SHA3_256/SHAKE256, 72 B SHA3_512, 168 B SHAKE128.
//   fill is 8 bits and never exceeds rate.
// CONFIGURATION
//  KECCAK_KEEP_CHECK_EN defined:
//   - adds output err_o (1 bit, reset 0).
//   - err_o is set sticky when an accepted s_keep_i is non-contiguous, or n==0
//     without s_last_i; cleared by start_i.
//   - the offending beat is still consumed using popcount.
//  Undefined: no err_o port, no check logic; bench must drive legal keep only.
// STRUCTURE
//  keccak_pkg additions:
//   - MAX_RATE_BYTES=168
//   - function rate_bytes(keccak_mode)
//   - SHA3_SUFFIX=8'h06, SHAKE_SUFFIX=8'h1F, PAD_END=8'h80
//   - absorb_state_t enum {IDLE, FILL, EMIT, PAD_ONLY, EMIT_LAST}
//  Sub-module keccak_byte_writer: combinational byte-lane shifter that places n
//   bytes at offset fill and splits overflow into the carry. FSM and buffers stay
//   in the top.
// TESTING
//  1. SHA3_256, single beat keep=0, last=1 -> one block, byte0=0x06,
//     byte135=0x80, rest 0, m_last=1.
//  2. SHA3_512, 71 bytes (2x32 + 7, last) -> byte70 = msg, byte71=0x86,
//     m_last=1, bytes>=72 zero.
//  3. SHAKE128, 168 bytes (5x32 + 8, last) -> full block m_last=0, then pad-only
//     block: byte0=0x1F, byte167=0x80, m_last=1.
//  4. SHA3_256, 160 bytes of 0xAA (5 full beats, last) -> block1 = 136x0xAA,
//     m_last=0; block2 bytes0..23=0xAA, byte24=0x06, byte135=0x80.
//  5. Backpressure: hold m_ready_i=0 for 10 cycles -> m_block_o stable,
//     s_ready_o=0, no beats lost.
//  6. Assert rst_n=0 mid-FILL, then new start_i -> outputs at reset values;
//     next message output unaffected by old data.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants, types and helpers for the Keccak absorb path.
//   DWIDTH / KEEP_WIDTH   input beat width in bits / bytes
//   MAX_RATE_BYTES        largest rate (SHAKE128), sizes the block buffer
//   keccak_mode_t         SHA3_256 / SHA3_512 / SHAKE128 / SHAKE256
//   absorb_state_t        absorb FSM states
//   rate_bytes()          rate in bytes for a mode
//   suffix_byte()         domain-separation suffix for a mode
//   popcount_keep()       byte count of a keep mask
//   keep_contiguous()     keep mask is a run of ones starting at bit 0
//   apply_pad()           domain suffix at offset, pad10*1 end bit at rate-1
package keccak_pkg;

    localparam int DWIDTH         = 256;
    localparam int KEEP_WIDTH     = DWIDTH / 8;
    localparam int MODE_SEL_WIDTH = 2;
    localparam int MAX_RATE_BYTES = 168;
    localparam int BLOCK_W        = MAX_RATE_BYTES * 8;
    localparam int CNT_W          = 6;   // holds 0..KEEP_WIDTH

    localparam logic [7:0] SHA3_SUFFIX  = 8'h06;
    localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;
    localparam logic [7:0] PAD_END      = 8'h80;

    typedef enum logic [MODE_SEL_WIDTH-1:0] {
        SHA3_256 = 2'd0,
        SHA3_512 = 2'd1,
        SHAKE128 = 2'd2,
        SHAKE256 = 2'd3
    } keccak_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        EMIT,
        PAD_ONLY,
        EMIT_LAST
    } absorb_state_t;

    function automatic logic [7:0] rate_bytes(input keccak_mode_t mode);
        case (mode)
            SHA3_512: return 8'd72;
            SHAKE128: return 8'd168;
            default:  return 8'd136;
        endcase
    endfunction

    function automatic logic [7:0] suffix_byte(input keccak_mode_t mode);
        return (mode == SHAKE128 || mode == SHAKE256) ? SHAKE_SUFFIX : SHA3_SUFFIX;
    endfunction

    function automatic logic [CNT_W-1:0] popcount_keep(input logic [KEEP_WIDTH-1:0] keep);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) cnt = cnt + CNT_W'(keep[i]);
        return cnt;
    endfunction

    // A contiguous-from-bit-0 mask plus one has no bits in common with itself.
    function automatic logic keep_contiguous(input logic [KEEP_WIDTH-1:0] keep);
        return (keep & (keep + KEEP_WIDTH'(1))) == '0;
    endfunction

    // XOR-based so suffix and end bit merge into one byte when off == rate-1.
    function automatic logic [BLOCK_W-1:0] apply_pad(input logic [BLOCK_W-1:0] blk,
                                                     input logic [7:0] off,
                                                     input logic [7:0] rate,
                                                     input logic [7:0] sfx);
        logic [BLOCK_W-1:0] res;
        logic [7:0]         last_b;
        res    = blk;
        last_b = rate - 8'd1;
        res[{off, 3'b000} +: 8]    = res[{off, 3'b000} +: 8] ^ sfx;
        res[{last_b, 3'b000} +: 8] = res[{last_b, 3'b000} +: 8] ^ PAD_END;
        return res;
    endfunction

endpackage

// File: rtl/keccak_byte_writer.sv
// keccak_byte_writer: combinational byte-lane shifter.
//   i_buf     current block buffer (bytes >= i_fill are zero)
//   i_fill    current fill in bytes
//   i_rate    rate in bytes for the active mode
//   i_data    beat data, byte k at bits [8k+7:8k]
//   i_n       number of valid bytes in the beat (low bytes)
//   o_buf     buffer with the beat placed at offset i_fill, clipped at rate
//   o_fill    new fill, saturated at rate
//   o_full    fill + n reaches rate
//   o_over    fill + n exceeds rate (beat straddles the block boundary)
//   o_carry   overflow bytes re-based to offset 0
//   o_carry_n number of overflow bytes
module keccak_byte_writer
    import keccak_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_buf,
    input  logic [7:0]         i_fill,
    input  logic [7:0]         i_rate,
    input  logic [DWIDTH-1:0]  i_data,
    input  logic [CNT_W-1:0]   i_n,
    output logic [BLOCK_W-1:0] o_buf,
    output logic [7:0]         o_fill,
    output logic               o_full,
    output logic               o_over,
    output logic [DWIDTH-1:0]  o_carry,
    output logic [CNT_W-1:0]   o_carry_n
);

    logic [DWIDTH-1:0]  w_nmask;
    logic [BLOCK_W-1:0] w_rmask;
    logic [DWIDTH-1:0]  w_data_m;
    logic [BLOCK_W-1:0] w_shift;
    logic [8:0]         w_sum;
    logic [7:0]         w_room;

    // Only the low n bytes of the beat are meaningful.
    for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_nmask
        assign w_nmask[8*k +: 8] = {8{CNT_W'(k) < i_n}};
    end

    // Bytes at or above the rate must stay zero in the block.
    for (genvar j = 0; j < MAX_RATE_BYTES; j++) begin : g_rmask
        assign w_rmask[8*j +: 8] = {8{8'(j) < i_rate}};
    end

    assign w_data_m  = i_data & w_nmask;
    assign w_shift   = BLOCK_W'(w_data_m) << {i_fill, 3'b000};
    assign o_buf     = i_buf | (w_shift & w_rmask);

    assign w_sum     = {1'b0, i_fill} + {3'b000, i_n};
    assign o_full    = w_sum >= {1'b0, i_rate};
    assign o_over    = w_sum > {1'b0, i_rate};
    assign o_fill    = o_full ? i_rate : w_sum[7:0];

    // Bytes that did not fit start at beat byte (rate - fill).
    assign w_room    = i_rate - i_fill;
    assign o_carry   = o_over ? (w_data_m >> {w_room, 3'b000}) : '0;
    assign o_carry_n = o_over ? CNT_W'(w_sum - {1'b0, i_rate}) : '0;

endmodule

// File: rtl/keccak_absorb_pad.sv
// keccak_absorb_pad: packs DWIDTH-bit input beats into rate-sized blocks for the
// selected Keccak mode, applies domain suffix plus pad10*1, and hands blocks to
// the permutation core. Beat width and buffer size come from keccak_pkg.
// Optional macro KECCAK_KEEP_CHECK_EN adds a sticky err_o for illegal keep masks.
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        begin message (IDLE only); latches mode_i, clears buffer
//   mode_i         keccak_mode_t selector
//   s_data_i/s_keep_i/s_last_i/s_valid_i/s_ready_o   input beat stream
//   m_block_o      rate block, bytes >= rate are zero
//   m_last_o       block is the padded final block
//   m_valid_o/m_ready_i   block handshake
//   busy_o         FSM not in IDLE
//   err_o          (KECCAK_KEEP_CHECK_EN only) sticky keep error, cleared by start
module keccak_absorb_pad
    import keccak_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [MODE_SEL_WIDTH-1:0] mode_i,
    input  logic [DWIDTH-1:0]         s_data_i,
    input  logic [KEEP_WIDTH-1:0]     s_keep_i,
    input  logic                      s_last_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [BLOCK_W-1:0]        m_block_o,
    output logic                      m_last_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic                      busy_o
`ifdef KECCAK_KEEP_CHECK_EN
    ,
    output logic                      err_o
`endif
);

    absorb_state_t      r_state;
    keccak_mode_t       r_mode;
    logic [7:0]         r_rate;
    logic [BLOCK_W-1:0] r_buf;
    logic [7:0]         r_fill;
    logic [DWIDTH-1:0]  r_carry;
    logic [CNT_W-1:0]   r_carry_n;
    logic               r_carry_pend;  // straddle bytes waiting for the next block
    logic               r_carry_last;  // straddling beat was the message end
    logic               r_pad_pend;    // message ended exactly on a block boundary

    logic               w_accept;
    logic [CNT_W-1:0]   w_n;
    logic [7:0]         w_sfx;
    logic [BLOCK_W-1:0] w_buf_wr;
    logic [7:0]         w_fill_new;
    logic               w_full;
    logic               w_over;
    logic [DWIDTH-1:0]  w_carry;
    logic [CNT_W-1:0]   w_carry_n;
    logic [BLOCK_W-1:0] w_carry_blk;

    assign s_ready_o   = (r_state == FILL) && !r_carry_pend;
    assign w_accept    = s_valid_i && s_ready_o;
    assign w_n         = popcount_keep(s_keep_i);
    assign w_sfx       = suffix_byte(r_mode);
    assign w_carry_blk = BLOCK_W'(r_carry);

    // The block buffer doubles as the output register.
    assign m_block_o   = r_buf;
    assign m_valid_o   = (r_state == EMIT) || (r_state == EMIT_LAST);
    assign m_last_o    = (r_state == EMIT_LAST);
    assign busy_o      = (r_state != IDLE);

    keccak_byte_writer u_writer (
        .i_buf     (r_buf),
        .i_fill    (r_fill),
        .i_rate    (r_rate),
        .i_data    (s_data_i),
        .i_n       (w_n),
        .o_buf     (w_buf_wr),
        .o_fill    (w_fill_new),
        .o_full    (w_full),
        .o_over    (w_over),
        .o_carry   (w_carry),
        .o_carry_n (w_carry_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_mode       <= SHA3_256;
            r_rate       <= 8'd136;
            r_buf        <= '0;
            r_fill       <= '0;
            r_carry      <= '0;
            r_carry_n    <= '0;
            r_carry_pend <= 1'b0;
            r_carry_last <= 1'b0;
            r_pad_pend   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_mode       <= keccak_mode_t'(mode_i);
                        r_rate       <= rate_bytes(keccak_mode_t'(mode_i));
                        r_buf        <= '0;
                        r_fill       <= '0;
                        r_carry_pend <= 1'b0;
                        r_carry_last <= 1'b0;
                        r_pad_pend   <= 1'b0;
                        r_state      <= FILL;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        if (w_full) begin
                            r_buf        <= w_buf_wr;
                            r_fill       <= w_fill_new;
                            r_carry      <= w_carry;
                            r_carry_n    <= w_carry_n;
                            r_carry_pend <= w_over;
                            r_carry_last <= w_over && s_last_i;
                            r_pad_pend   <= !w_over && s_last_i;
                            r_state      <= EMIT;
                        end else if (s_last_i) begin
                            r_buf   <= apply_pad(w_buf_wr, w_fill_new, r_rate, w_sfx);
                            r_fill  <= w_fill_new;
                            r_state <= EMIT_LAST;
                        end else begin
                            r_buf  <= w_buf_wr;
                            r_fill <= w_fill_new;
                        end
                    end
                end
                EMIT: begin
                    if (m_ready_i) begin
                        r_carry_pend <= 1'b0;
                        r_carry_last <= 1'b0;
                        r_pad_pend   <= 1'b0;
                        if (r_carry_pend) begin
                            // Carry always fits: it is shorter than one beat.
                            r_fill <= {2'b00, r_carry_n};
                            if (r_carry_last) begin
                                r_buf   <= apply_pad(w_carry_blk, {2'b00, r_carry_n}, r_rate, w_sfx);
                                r_state <= EMIT_LAST;
                            end else begin
                                r_buf   <= w_carry_blk;
                                r_state <= FILL;
                            end
                        end else begin
                            r_buf   <= '0;
                            r_fill  <= '0;
                            r_state <= r_pad_pend ? PAD_ONLY : FILL;
                        end
                    end
                end
                PAD_ONLY: begin
                    r_buf   <= apply_pad('0, 8'd0, r_rate, w_sfx);
                    r_state <= EMIT_LAST;
                end
                EMIT_LAST: begin
                    if (m_ready_i) begin
                        r_buf   <= '0;
                        r_fill  <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef KECCAK_KEEP_CHECK_EN
    logic r_err;
    assign err_o = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && start_i) begin
            r_err <= 1'b0;
        end else if (w_accept && (!keep_contiguous(s_keep_i) || (w_n == '0 && !s_last_i))) begin
            r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_keccak_absorb_pad.sv
// tb_keccak_absorb_pad: directed scoreboard bench for keccak_absorb_pad.
// Stimulus pushes the expected padded blocks (from a byte-level pad model)
// into a queue; a monitor pops and compares on every block handshake.
module tb_keccak_absorb_pad;
    import keccak_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_i = 1'b0;
    logic [1:0]           mode_i = 2'd0;
    logic [DWIDTH-1:0]    s_data_i = '0;
    logic [KEEP_WIDTH-1:0] s_keep_i = '0;
    logic                 s_last_i = 1'b0;
    logic                 s_valid_i = 1'b0;
    logic                 s_ready_o;
    logic [BLOCK_W-1:0]   m_block_o;
    logic                 m_last_o;
    logic                 m_valid_o;
    logic                 m_ready_i = 1'b1;
    logic                 busy_o;
`ifdef KECCAK_KEEP_CHECK_EN
    logic                 err_o;
`endif

    keccak_absorb_pad dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .s_data_i  (s_data_i),
        .s_keep_i  (s_keep_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_block_o (m_block_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .busy_o    (busy_o)
`ifdef KECCAK_KEEP_CHECK_EN
        ,
        .err_o     (err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BLOCK_W-1:0] blk;
        logic               last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] msg [0:255];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
        int idx;
        checks++;
        if (act !== exp) begin
            failures++;
            idx = 0;
            for (int j = MAX_RATE_BYTES - 1; j >= 0; j--)
                if (act[j*8 +: 8] !== exp[j*8 +: 8]) idx = j;
            $display("FAIL %s: byte %0d got %02h expected %02h", nm, idx,
                     act[idx*8 +: 8], exp[idx*8 +: 8]);
        end
    endtask

    // Monitor: compare every accepted block against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_block: got block with last=%0d expected none", m_last_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk_blk("block", m_block_o, mon_e.blk);
                chk("m_last", {31'd0, m_last_o}, {31'd0, mon_e.last});
            end
        end
    end

    function automatic int rate_of(input keccak_mode_t md);
        case (md)
            SHA3_512: return 72;
            SHAKE128: return 168;
            default:  return 136;
        endcase
    endfunction

    // Standard padding over the byte stream: msg || suffix ... 0x80 to a rate multiple.
    task automatic push_expected(input keccak_mode_t md, input int len);
        logic [7:0] p [0:511];
        int         r;
        int         nb;
        logic [7:0] sfx;
        exp_t       e;
        r   = rate_of(md);
        nb  = len / r + 1;
        sfx = (md == SHAKE128 || md == SHAKE256) ? 8'h1F : 8'h06;
        for (int i = 0; i < 512; i++) p[i] = 8'h00;
        for (int i = 0; i < len; i++) p[i] = msg[i];
        p[len]        = p[len] ^ sfx;
        p[nb * r - 1] = p[nb * r - 1] ^ 8'h80;
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int j = 0; j < r; j++) e.blk[j*8 +: 8] = p[b * r + j];
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_msg(input int len, input int seed);
        for (int i = 0; i < len; i++) msg[i] = 8'((i * 7 + seed) & 8'hFF);
    endtask

    // All drive tasks start and end at posedge + 1.
    task automatic start_msg(input keccak_mode_t md);
        start_i = 1'b1;
        mode_i  = md;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic drive_beat(input logic [DWIDTH-1:0] d, input logic [KEEP_WIDTH-1:0] k, input logic l);
        int t;
        s_data_i  = d;
        s_keep_i  = k;
        s_last_i  = l;
        s_valid_i = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_ready_o) break;
            t++;
            if (t > 300) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout: s_ready stayed 0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        s_keep_i  = '0;
    endtask

    task automatic send_beats(input int len, input logic with_last);
        int               off;
        int               nbeat;
        logic [DWIDTH-1:0] d;
        logic [KEEP_WIDTH-1:0] k;
        off = 0;
        do begin
            nbeat = (len - off > KEEP_WIDTH) ? KEEP_WIDTH : len - off;
            d = '0;
            k = '0;
            for (int b = 0; b < nbeat; b++) begin
                d[b*8 +: 8] = msg[off + b];
                k[b] = 1'b1;
            end
            drive_beat(d, k, with_last && (off + nbeat == len));
            off += nbeat;
        end while (off < len);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((busy_o || exp_q.size() != 0) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("busy_after_msg", {31'd0, busy_o}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic run_msg(input keccak_mode_t md, input int len);
        push_expected(md, len);
        start_msg(md);
        send_beats(len, 1'b1);
        wait_done();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready_o}, 32'd0);
        chk({tag, "_m_valid"}, {31'd0, m_valid_o}, 32'd0);
        chk({tag, "_m_last"},  {31'd0, m_last_o},  32'd0);
        chk({tag, "_busy"},    {31'd0, busy_o},    32'd0);
        chk_blk({tag, "_m_block"}, m_block_o, '0);
    endtask

    task automatic bp_watch();
        int t;
        t = 0;
        while (!m_valid_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", {31'd0, m_valid_o}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_blk("bp_hold", m_block_o, exp_q[0].blk);
            chk("bp_s_ready", {31'd0, s_ready_o}, 32'd0);
        end
        @(posedge clk); #1;
        m_ready_i = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty message: single pad block.
        run_msg(SHA3_256, 0);
        // 71 bytes: suffix and end bit share byte 71 (0x86).
        fill_msg(71, 3);
        run_msg(SHA3_512, 71);
        // Exactly one block of data, then a pad-only block.
        fill_msg(168, 5);
        run_msg(SHAKE128, 168);
        // 160 bytes of 0xAA: last beat straddles, pad lands at byte 24.
        for (int i = 0; i < 160; i++) msg[i] = 8'hAA;
        run_msg(SHA3_256, 160);
        // Straddling final beat in SHAKE256.
        fill_msg(150, 9);
        run_msg(SHAKE256, 150);

        // Backpressure on the first block with a straddling beat behind it.
        fill_msg(100, 11);
        push_expected(SHA3_512, 100);
        m_ready_i = 1'b0;
        fork
            begin
                start_msg(SHA3_512);
                send_beats(100, 1'b1);
            end
            bp_watch();
        join
        wait_done();

        // Reset mid-FILL, then a fresh message must be clean.
        fill_msg(64, 13);
        start_msg(SHA3_256);
        send_beats(64, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_msg(40, 17);
        run_msg(SHAKE128, 40);

`ifdef KECCAK_KEEP_CHECK_EN
        chk("err_clear", {31'd0, err_o}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: sim time limit reached expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
